// File: rtl/alu_md_if.sv
// Request/response bundle between the execute stage and the alu_md block.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. The
// producer keeps its payload stable while valid is high and ready is low.
interface alu_md_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;
  logic [1:0]      dbg_state;

  modport master (
    output in_valid, alu_op, src_a, src_b, flush, out_ready,
    input  in_ready, out_valid, result, zero, busy, dbg_state
  );

  modport slave (
    input  in_valid, alu_op, src_a, src_b, flush, out_ready,
    output in_ready, out_valid, result, zero, busy, dbg_state
  );
endinterface

// File: rtl/alu_md.sv
// Multi-cycle integer ALU: RV base ops in one edge, M-extension ops on a
// shared radix-2 engine (shift-add multiply / restoring divide) over
// unsigned magnitudes, with the sign fixed up on the final iteration.
module alu_md #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_md_if.slave bus
);
  localparam int SW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_SLTU = 5'b01111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [SW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, dvs;
  logic [XLEN-1:0] result_q;
  logic [2:0]      op_q;
  logic            neg_q;   // negate product / quotient
  logic            neg_r;   // negate remainder (dividend was negative)

  // Request decode
  logic            in_ready;
  logic            accept;
  logic            m_op;
  logic [2:0]      f3;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] base_res;
  logic [SW-1:0]   shamt;

  assign in_ready = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign m_op     = bus.alu_op[4];
  assign f3       = bus.alu_op[2:0];
  assign shamt    = bus.src_b[SW-1:0];

  // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
  assign a_sgn = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
  assign b_sgn = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  assign a_neg = a_sgn && bus.src_a[XLEN-1];
  assign b_neg = b_sgn && bus.src_b[XLEN-1];
  assign a_mag = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag = b_neg ? -bus.src_b : bus.src_b;

  // Divide by zero and signed overflow finish without iterating
  assign div_zero = f3[2] && (bus.src_b == '0);
  assign div_ovf  = f3[2] && !f3[0] && (bus.src_a == MIN_NEG) && (bus.src_b == '1);
  assign fast     = div_zero || div_ovf;
  assign fast_res = div_zero ? (f3[1] ? bus.src_a : '1) : (f3[1] ? '0 : bus.src_a);

  // Single-edge base operations
  always_comb begin
    base_res = '0;
    case (bus.alu_op)
      OP_AND:  base_res = bus.src_a & bus.src_b;
      OP_OR:   base_res = bus.src_a | bus.src_b;
      OP_ADD:  base_res = bus.src_a + bus.src_b;
      OP_SUB:  base_res = bus.src_a - bus.src_b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_SLL:  base_res = bus.src_a << shamt;
      OP_SRL:  base_res = bus.src_a >> shamt;
      OP_XOR:  base_res = bus.src_a ^ bus.src_b;
      OP_SRA:  base_res = $unsigned($signed(bus.src_a) >>> shamt);
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
      default: base_res = '0;
    endcase
  end

  // Engine step: multiply adds the multiplicand into the high half when the
  // low bit of the multiplier is set and shifts right; divide shifts the
  // dividend left into the partial remainder and subtracts when it fits.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [XLEN:0]   div_sh, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_hi, div_lo;
  logic [XLEN-1:0] nxt_hi, nxt_lo;

  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
  assign mul_hi   = mul_sum[XLEN:1];
  assign mul_lo   = {mul_sum[0], lo[XLEN-1:1]};
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_diff = div_sh - {1'b0, dvs};
  assign div_ge   = !div_diff[XLEN];
  assign div_hi   = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign div_lo   = {lo[XLEN-2:0], div_ge};
  assign nxt_hi   = op_q[2] ? div_hi : mul_hi;
  assign nxt_lo   = op_q[2] ? div_lo : mul_lo;

  // Sign correction and result selection for the last iteration
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign prod     = {nxt_hi, nxt_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -nxt_lo : nxt_lo;
  assign rem_fix  = neg_r ? -nxt_hi : nxt_hi;

  // Pick quotient/remainder or low/high product half
  always_comb begin
    final_res = '0;
    if (op_q[2])
      final_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00)
      final_res = prod_fix[XLEN-1:0];
    else
      final_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Control FSM, engine registers and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else if (state == S_CALC) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + SW'(1);
      if (cnt == SW'(XLEN-1)) begin
        state    <= S_DONE;
        result_q <= final_res;
      end
    end else if (accept) begin
      if (!m_op) begin
        result_q <= base_res;
        state    <= S_DONE;
      end else if (fast) begin
        result_q <= fast_res;
        state    <= S_DONE;
      end else begin
        state <= S_CALC;
        cnt   <= '0;
        hi    <= '0;
        lo    <= f3[2] ? a_mag : b_mag;
        dvs   <= f3[2] ? b_mag : a_mag;
        op_q  <= f3;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end
    end else if (state == S_DONE && bus.out_ready) begin
      state <= S_IDLE;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_CALC);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.dbg_state = state;
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised, multi-cycle successor to the single-cycle integer ALU. It executes every base RV integer operation, adds arithmetic right shift, and adds the full M-extension set: multiply, multiply-high, divide and remainder. It sits in the execute stage behind a valid/ready handshake:

- Base ops return one cycle after acceptance.
- Multiply/divide ops run a radix-2 iterative engine for XLEN cycles.

## Interface
- `XLEN`, default 32: operand and result width. Must be ≥ 8 and a power of two.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: request present on `alu_op`/`src_a`/`src_b`.
- `in_ready` output 1: block can accept a request this cycle.
- `alu_op` input 5: operation code (encodings below).
- `src_a` input XLEN: operand A (dividend, multiplicand, shift source).
- `src_b` input XLEN: operand B (divisor, multiplier, shift amount in bits [log2(XLEN)-1:0]).
- `flush` input 1: synchronous abort of any in-flight or held result.
- `out_valid` output 1: `result`/`zero` valid.
- `out_ready` input 1: consumer takes the result this cycle.
- `result` output XLEN: registered result.
- `zero` output 1: high when `result` == 0 (combinational from the result register).
- `busy` output 1: high while in CALC.

## Operation
- Opcodes with `alu_op[4]`=0 are base ops:
  - AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, SLL 01000, SRL 01001, XOR 01010, SRA 01101, SLTU 01111.
- Opcodes with `alu_op[4]`=1 are M ops, with `alu_op[2:0]` = RV funct3:
  - MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
  - `alu_op[3]` is ignored for M ops.
- Any base encoding not listed yields result 0 with base latency.
- Acceptance occurs when `in_valid && in_ready`. Operands and op are captured at the accepting edge; later changes on the inputs have no effect.
- State machine: IDLE, CALC, DONE.
  - IDLE → DONE on acceptance of a base op or a fast-path M op.
  - IDLE → CALC on acceptance of any other M op. The iteration counter is cleared to 0.
  - CALC: one iteration per edge. After iteration XLEN-1 completes, go to DONE with the final sign correction applied.
  - DONE: `out_valid`=1. `result` is held stable until `out_ready`. On `out_ready`, go to IDLE, or take the next request directly (IDLE transitions apply) if one is accepted on the same edge.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- Arithmetic rules, all modulo 2^XLEN:
  - SLT/SLTU return 1 or 0.
  - SRA replicates `src_a[XLEN-1]`.
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU and MULHU return the high XLEN bits of the 2·XLEN product:
    - MULH: signed × signed.
    - MULHSU: signed A × unsigned B.
    - MULHU: unsigned × unsigned.
  - DIV/REM truncate toward zero. The remainder takes the sign of the dividend.
- Fast path (DONE after one edge, no CALC):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `src_a`.
  - Signed overflow (`src_a` = 1 followed by zeros, `src_b` = all ones): DIV → `src_a`; REM → 0.
- `flush` has priority over everything, including acceptance on the same edge. Next state is IDLE and `out_valid` drops on the next edge; an aborted result is never presented.

## Timing
- Reset values: state IDLE, `result` 0, `out_valid` 0, `busy` 0, `zero` 1, `in_ready` 1.
- Reset asserted mid-CALC or in DONE discards the operation immediately (asynchronous).
- Latency from accepting edge to `out_valid` high:
  - Base op or fast path: 1 edge.
  - Iterative M op: XLEN+1 edges (33 for XLEN=32).
- Throughput: one base op per cycle while `out_ready` is held high. Back-to-back iterative ops start every XLEN+1 cycles.
- `busy` is high for exactly XLEN cycles per iterative op.
- `in_ready` is low throughout CALC, and low in DONE while `out_ready`=0.

## Test plan
- Reset release, then ADD 5+7, then SRA 0x80000000>>4 with `out_ready`=1 → 12 on the edge after acceptance, then 0xF8000000; `zero`=0 for both.
- SUB 3-3 → `result` 0, `zero`=1. Unlisted base op 00011 → 0 after 1 cycle.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU of the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. Each op: `out_valid` exactly 33 edges after acceptance and `busy` high for 32 cycles.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF after 1 edge; DIV 0x80000000/-1 → 0x80000000 after 1 edge.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `result` stable, `in_ready`=0. Raise `out_ready` together with `in_valid` (new ADD) → next result 1 edge later with no bubble.
- `flush` at iteration 10 of a DIVU, and separately `rst_n` low mid-CALC → `out_valid` never rises for that op; state returns to IDLE, `in_ready`=1.
